// File: rtl/axi4_apb_burst_bridge.sv
// axi4_apb_burst_bridge: AXI4 slave to APB master bridge that serialises one FIXED/INCR
// burst at a time into single 32-bit APB transfers, with per-beat read and aggregated write responses.
module axi4_apb_burst_bridge #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ID_W-1:0]   awid,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [7:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic [2:0]        awprot,
    input  logic              wvalid,
    output logic              wready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    output logic              bvalid,
    input  logic              bready,
    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ID_W-1:0]   arid,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic [2:0]        arprot,
    output logic              rvalid,
    input  logic              rready,
    output logic [ID_W-1:0]   rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              out_psel,
    output logic              out_penable,
    output logic              out_pwrite,
    output logic [ADDR_W-1:0] out_paddr,
    output logic [2:0]        out_pprot,
    output logic [31:0]       out_pwdata,
    output logic [3:0]        out_pstrb,
    input  logic              out_pready,
    input  logic [31:0]       out_prdata,
    input  logic              out_pslverr
);
    typedef enum logic [2:0] {IDLE, WDAT, WSET, WACC, BRSP, RSET, RACC, RDAT} state_t;

    state_t            state_q, state_d;
    logic              prefer_w_q, prefer_w_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        burst_q, burst_d;
    logic [2:0]        prot_q, prot_d;
    logic              err_q, err_d;
    logic [7:0]        beat_q, beat_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              werr_q, werr_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              rlast_q, rlast_d;

    logic              aw_hs, ar_hs, last, wlast_unused;
    logic [ADDR_W-1:0] next_addr;

    // Beat count comes from awlen, so wlast carries no information here.
    assign wlast_unused = wlast;

    // Ready only in IDLE; on a simultaneous request the type not served last wins.
    assign awready = reset_n && state_q == IDLE && (!arvalid || prefer_w_q);
    assign arready = reset_n && state_q == IDLE && (!awvalid || !prefer_w_q);
    assign aw_hs   = awvalid && awready;
    assign ar_hs   = arvalid && arready;
    assign last    = beat_q == len_q;
    assign next_addr = burst_q == 2'b01 ? addr_q + (ADDR_W'(1) << size_q) : addr_q;

    always_comb begin
        state_d    = state_q;
        prefer_w_d = prefer_w_q;
        id_d       = id_q;
        addr_d     = addr_q;
        len_d      = len_q;
        size_d     = size_q;
        burst_d    = burst_q;
        prot_d     = prot_q;
        err_d      = err_q;
        beat_d     = beat_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        werr_d     = werr_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rlast_d    = rlast_q;
        case (state_q)
            IDLE: begin
                if (ar_hs) begin
                    state_d    = RSET;
                    prefer_w_d = 1'b1;
                    id_d       = arid;
                    addr_d     = araddr;
                    len_d      = arlen;
                    size_d     = arsize;
                    burst_d    = arburst;
                    prot_d     = arprot;
                    err_d      = arsize > 3'd2 || arburst[1];
                    beat_d     = 8'd0;
                end else if (aw_hs) begin
                    state_d    = WDAT;
                    prefer_w_d = 1'b0;
                    id_d       = awid;
                    addr_d     = awaddr;
                    len_d      = awlen;
                    size_d     = awsize;
                    burst_d    = awburst;
                    prot_d     = awprot;
                    err_d      = awsize > 3'd2 || awburst[1];
                    werr_d     = awsize > 3'd2 || awburst[1];
                    beat_d     = 8'd0;
                end
            end
            WDAT: begin
                if (wvalid) begin
                    wdata_d = wdata;
                    wstrb_d = wstrb;
                    state_d = WSET;
                end
            end
            WSET: begin
                // An unsupported burst drains its data without touching the APB bus.
                if (err_q) begin
                    beat_d  = beat_q + 8'd1;
                    state_d = last ? BRSP : WDAT;
                end else begin
                    state_d = WACC;
                end
            end
            WACC: begin
                if (out_pready) begin
                    werr_d  = werr_q | out_pslverr;
                    beat_d  = beat_q + 8'd1;
                    addr_d  = next_addr;
                    state_d = last ? BRSP : WDAT;
                end
            end
            BRSP: state_d = bready ? IDLE : BRSP;
            RSET: begin
                if (err_q) begin
                    rdata_d = 32'd0;
                    rresp_d = 2'b10;
                    rlast_d = last;
                    beat_d  = beat_q + 8'd1;
                    state_d = RDAT;
                end else begin
                    state_d = RACC;
                end
            end
            RACC: begin
                if (out_pready) begin
                    rdata_d = out_prdata;
                    rresp_d = out_pslverr ? 2'b10 : 2'b00;
                    rlast_d = last;
                    beat_d  = beat_q + 8'd1;
                    addr_d  = next_addr;
                    state_d = RDAT;
                end
            end
            RDAT: state_d = rready ? (rlast_q ? IDLE : RSET) : RDAT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            prefer_w_q <= 1'b0;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            prot_q     <= '0;
            err_q      <= 1'b0;
            beat_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            werr_q     <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            rlast_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            prefer_w_q <= prefer_w_d;
            id_q       <= id_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            size_q     <= size_d;
            burst_q    <= burst_d;
            prot_q     <= prot_d;
            err_q      <= err_d;
            beat_q     <= beat_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            werr_q     <= werr_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rlast_q    <= rlast_d;
        end
    end

    assign wready      = state_q == WDAT;
    assign bvalid      = state_q == BRSP;
    assign bid         = id_q;
    assign bresp       = werr_q ? 2'b10 : 2'b00;
    assign rvalid      = state_q == RDAT;
    assign rid         = id_q;
    assign rdata       = rdata_q;
    assign rresp       = rresp_q;
    assign rlast       = rlast_q;
    assign out_psel    = (state_q inside {WSET, WACC, RSET, RACC}) && !err_q;
    assign out_penable = state_q inside {WACC, RACC};
    assign out_pwrite  = (state_q inside {WSET, WACC}) && !err_q;
    assign out_paddr   = addr_q;
    assign out_pprot   = prot_q;
    assign out_pwdata  = wdata_q;
    assign out_pstrb   = out_pwrite ? wstrb_q : 4'h0;
endmodule

// File: tb/tb_axi4_apb_burst_bridge.sv
// tb_axi4_apb_burst_bridge: directed and randomized bursts against a burst-level model of the bridge,
// with the bench acting as AXI master and APB slave.
module tb_axi4_apb_burst_bridge;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        awvalid = 0, awready;
    logic [3:0]  awid = 0;
    logic [31:0] awaddr = 0;
    logic [7:0]  awlen = 0;
    logic [2:0]  awsize = 0;
    logic [1:0]  awburst = 0;
    logic [2:0]  awprot = 0;
    logic        wvalid = 0, wready;
    logic [31:0] wdata = 0;
    logic [3:0]  wstrb = 0;
    logic        wlast = 0;
    logic        bvalid, bready = 0;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        arvalid = 0, arready;
    logic [3:0]  arid = 0;
    logic [31:0] araddr = 0;
    logic [7:0]  arlen = 0;
    logic [2:0]  arsize = 0;
    logic [1:0]  arburst = 0;
    logic [2:0]  arprot = 0;
    logic        rvalid, rready = 0;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        out_psel, out_penable, out_pwrite;
    logic [31:0] out_paddr;
    logic [2:0]  out_pprot;
    logic [31:0] out_pwdata;
    logic [3:0]  out_pstrb;
    logic        out_pready = 0;
    logic [31:0] out_prdata = 0;
    logic        out_pslverr = 0;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    axi4_apb_burst_bridge #(.ID_W(4), .ADDR_W(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .out_psel(out_psel), .out_penable(out_penable), .out_pwrite(out_pwrite),
        .out_paddr(out_paddr), .out_pprot(out_pprot), .out_pwdata(out_pwdata), .out_pstrb(out_pstrb),
        .out_pready(out_pready), .out_prdata(out_prdata), .out_pslverr(out_pslverr)
    );

    // Burst-level read: expected beat addresses, data and responses come from the burst rules.
    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len, input int size,
                           input int burst, input logic [2:0] prot, input int wait_n, input int err_beat,
                           input bit stall);
        int beat = 0, apb = 0, waitc = 0, cyc = 0;
        bit pend = 0, seen = 0, err, hs;
        logic [31:0] exp_data[$];
        logic [31:0] ea;
        logic [1:0] er;
        err = size > 2 || burst >= 2;
        arvalid = 1; arid = id; araddr = addr; arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst); arprot = prot;
        #1;
        while (arready !== 1'b1 && cyc < 50) begin @(posedge clock); #1; cyc++; end
        total++;
        if (arready !== 1'b1) begin
            bad++; $display("FAIL ar_accept arready=%b exp=1", arready); arvalid = 0; return;
        end
        @(posedge clock); #1;
        arvalid = 0;
        cyc = 0;
        while (beat <= len && cyc < 3000) begin
            ea = addr + ((burst == 1) ? (32'(apb) << size) : 32'd0);
            if (pend) begin
                total++;
                if (out_psel !== 1'b1 || out_penable !== 1'b1 || out_paddr !== ea) begin
                    bad++; $display("FAIL rd_access psel=%b penable=%b paddr=%h exp 1 1 %h", out_psel, out_penable, out_paddr, ea);
                end
                if (waitc >= wait_n) begin
                    out_pready = 1; out_prdata = $urandom; out_pslverr = (apb == err_beat);
                    exp_data.push_back(out_prdata); apb++; pend = 0;
                end else begin
                    out_pready = 0; out_pslverr = 0;
                end
                waitc++;
            end else begin
                out_pready = 0; out_pslverr = 0;
                total++;
                if (out_psel === 1'b1) begin
                    if (out_penable !== 1'b0 || out_paddr !== ea || out_pwrite !== 1'b0 || out_pstrb !== 4'h0 || out_pprot !== prot) begin
                        bad++; $display("FAIL rd_setup penable=%b paddr=%h pwrite=%b pstrb=%h pprot=%h exp 0 %h 0 0 %h",
                                        out_penable, out_paddr, out_pwrite, out_pstrb, out_pprot, ea, prot);
                    end
                    pend = 1; waitc = 0;
                end else if (out_penable !== 1'b0) begin
                    bad++; $display("FAIL penable_no_psel penable=%b exp=0", out_penable);
                end
            end
            rready = 0;
            if (rvalid === 1'b1) begin
                er = (err || beat == err_beat) ? 2'b10 : 2'b00;
                total++;
                if (rid !== id || rresp !== er || rlast !== (beat == len) ||
                    (!err && (beat >= exp_data.size() || rdata !== exp_data[beat]))) begin
                    bad++; $display("FAIL rd_beat%0d rid=%h rresp=%b rlast=%b rdata=%h exp %h %b %b %h", beat, rid, rresp, rlast,
                                    rdata, id, er, beat == len, beat < exp_data.size() ? exp_data[beat] : 32'h0);
                end
                rready = !(stall && !seen);
                seen = 1;
            end
            hs = rvalid && rready;
            @(posedge clock); #1;
            cyc++;
            if (hs) begin beat++; seen = 0; end
        end
        rready = 0; out_pready = 0; out_pslverr = 0;
        total++;
        if (beat != len + 1 || apb != (err ? 0 : len + 1) || rvalid !== 1'b0) begin
            bad++; $display("FAIL rd_count beats=%0d apb=%0d rvalid=%b exp %0d %0d 0", beat, apb, rvalid, len + 1, err ? 0 : len + 1);
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len, input int size,
                            input int burst, input logic [2:0] prot, input int wait_n, input int err_beat,
                            input int strb);
        int wb = 0, apb = 0, waitc = 0, cyc = 0;
        bit pend = 0, done = 0, err, hs;
        logic [31:0] wd[$];
        logic [3:0] ws[$];
        logic [31:0] ea;
        logic [1:0] eb;
        err = size > 2 || burst >= 2;
        for (int i = 0; i <= len; i++) begin
            wd.push_back($urandom);
            ws.push_back(strb < 0 ? 4'($urandom_range(0, 15)) : 4'(strb));
        end
        eb = (err || (err_beat >= 0 && err_beat <= len)) ? 2'b10 : 2'b00;
        awvalid = 1; awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst); awprot = prot;
        #1;
        while (awready !== 1'b1 && cyc < 50) begin @(posedge clock); #1; cyc++; end
        total++;
        if (awready !== 1'b1) begin
            bad++; $display("FAIL aw_accept awready=%b exp=1", awready); awvalid = 0; return;
        end
        @(posedge clock); #1;
        awvalid = 0;
        cyc = 0;
        while (!done && cyc < 3000) begin
            wvalid = wb <= len;
            if (wvalid) begin wdata = wd[wb]; wstrb = ws[wb]; end
            wlast = wb == len;
            ea = addr + ((burst == 1) ? (32'(apb) << size) : 32'd0);
            if (pend) begin
                total++;
                if (out_psel !== 1'b1 || out_penable !== 1'b1 || out_paddr !== ea) begin
                    bad++; $display("FAIL wr_access psel=%b penable=%b paddr=%h exp 1 1 %h", out_psel, out_penable, out_paddr, ea);
                end
                if (waitc >= wait_n) begin
                    out_pready = 1; out_pslverr = (apb == err_beat); apb++; pend = 0;
                end else begin
                    out_pready = 0; out_pslverr = 0;
                end
                waitc++;
            end else begin
                out_pready = 0; out_pslverr = 0;
                total++;
                if (out_psel === 1'b1) begin
                    if (apb > len || out_penable !== 1'b0 || out_paddr !== ea || out_pwrite !== 1'b1 ||
                        out_pwdata !== wd[apb] || out_pstrb !== ws[apb] || out_pprot !== prot) begin
                        bad++; $display("FAIL wr_setup apb=%0d penable=%b paddr=%h pwrite=%b pwdata=%h pstrb=%h pprot=%h exp paddr=%h",
                                        apb, out_penable, out_paddr, out_pwrite, out_pwdata, out_pstrb, out_pprot, ea);
                    end
                    pend = 1; waitc = 0;
                end else if (out_penable !== 1'b0) begin
                    bad++; $display("FAIL penable_no_psel penable=%b exp=0", out_penable);
                end
            end
            bready = 0;
            if (bvalid === 1'b1) begin
                total++;
                if (bid !== id || bresp !== eb || wb != len + 1 || apb != (err ? 0 : len + 1)) begin
                    bad++; $display("FAIL wr_resp bid=%h bresp=%b wbeats=%0d apb=%0d exp %h %b %0d %0d",
                                    bid, bresp, wb, apb, id, eb, len + 1, err ? 0 : len + 1);
                end
                bready = 1; done = 1;
            end
            hs = wvalid && wready;
            @(posedge clock); #1;
            cyc++;
            if (hs) wb++;
        end
        wvalid = 0; wlast = 0; bready = 0; out_pready = 0; out_pslverr = 0;
        total++;
        if (!done || bvalid !== 1'b0) begin
            bad++; $display("FAIL wr_done done=%b bvalid=%b exp 1 0", done, bvalid);
        end
    endtask

    task automatic apply_reset();
        @(posedge clock); #2;
        reset_n = 0;
        @(negedge clock);
        reset_n = 1;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        awvalid = 1; arvalid = 1;
        #1;
        total++;
        if ({awready, arready, wready, bvalid, rvalid, rlast, out_psel, out_penable, out_pwrite} !== 9'b0 ||
            {out_paddr, out_pwdata, out_pstrb, out_pprot, rdata, rresp, bresp, rid, bid} !== '0) begin
            bad++; $display("FAIL reset_outputs ctl=%b paddr=%h rdata=%h exp all zero",
                            {awready, arready, wready, bvalid, rvalid, rlast, out_psel, out_penable, out_pwrite}, out_paddr, rdata);
        end
        awvalid = 0; arvalid = 0;
        @(negedge clock);
        reset_n = 1;
        @(posedge clock); #1;
    endtask

    task automatic test_single_read();
        out_pready = 1; out_prdata = 32'hDEADBEEF; out_pslverr = 0;
        arvalid = 1; arid = 4'h3; araddr = 32'h8000_0010; arlen = 0; arsize = 2; arburst = 2'b01; arprot = 3'b010;
        #1;
        total++;
        if (arready !== 1'b1) begin bad++; $display("FAIL single_arready got=%b exp=1", arready); end
        @(posedge clock); #1;
        arvalid = 0;
        total++;
        if (out_psel !== 1'b1 || out_penable !== 1'b0 || out_paddr !== 32'h8000_0010 || out_pprot !== 3'b010) begin
            bad++; $display("FAIL single_setup psel=%b penable=%b paddr=%h exp 1 0 80000010", out_psel, out_penable, out_paddr);
        end
        @(posedge clock); #1;
        total++;
        if (out_psel !== 1'b1 || out_penable !== 1'b1 || rvalid !== 1'b0) begin
            bad++; $display("FAIL single_access psel=%b penable=%b rvalid=%b exp 1 1 0", out_psel, out_penable, rvalid);
        end
        @(posedge clock); #1;
        out_pready = 0;
        total++;
        if (rvalid !== 1'b1 || rdata !== 32'hDEADBEEF || rresp !== 2'b00 || rlast !== 1'b1 || rid !== 4'h3 || out_psel !== 1'b0) begin
            bad++; $display("FAIL single_rdata rvalid=%b rdata=%h rresp=%b rlast=%b rid=%h exp 1 deadbeef 00 1 3",
                            rvalid, rdata, rresp, rlast, rid);
        end
        rready = 1;
        @(posedge clock); #1;
        rready = 0;
        total++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            bad++; $display("FAIL single_done rvalid=%b arready=%b exp 0 1", rvalid, arready);
        end
    endtask

    task automatic test_incr_write();
        do_write(4'h5, 32'h100, 3, 2, 1, 3'b000, 0, -1, 4'b0110);
    endtask

    task automatic test_wait_slverr();
        do_read(4'h9, 32'h2000_0040, 2, 2, 1, 3'b001, 5, 1, 1'b0);
    endtask

    task automatic test_arbitration();
        apply_reset();
        awvalid = 1; awid = 4'hA; awaddr = 32'h300; awlen = 0; awsize = 2; awburst = 2'b01; awprot = 0;
        arvalid = 1; arid = 4'hB; araddr = 32'h400; arlen = 0; arsize = 2; arburst = 2'b01; arprot = 0;
        #1;
        total++;
        if (arready !== 1'b1 || awready !== 1'b0) begin
            bad++; $display("FAIL arb_first arready=%b awready=%b exp 1 0", arready, awready);
        end
        do_read(4'hB, 32'h400, 0, 2, 1, 3'b000, 0, -1, 1'b0);
        arvalid = 1;
        #1;
        total++;
        if (awready !== 1'b1 || arready !== 1'b0) begin
            bad++; $display("FAIL arb_second awready=%b arready=%b exp 1 0", awready, arready);
        end
        arvalid = 0;
        do_write(4'hA, 32'h300, 0, 2, 1, 3'b000, 0, -1, -1);
        awvalid = 1; arvalid = 1;
        #1;
        total++;
        if (arready !== 1'b1 || awready !== 1'b0) begin
            bad++; $display("FAIL arb_third arready=%b awready=%b exp 1 0", arready, awready);
        end
        do_read(4'hB, 32'h400, 1, 2, 1, 3'b000, 1, -1, 1'b1);
        do_write(4'hA, 32'h300, 1, 2, 1, 3'b000, 1, -1, -1);
    endtask

    task automatic test_error_bursts();
        do_read(4'h1, 32'h500, 1, 2, 2, 3'b000, 0, -1, 1'b0);
        do_write(4'h2, 32'h600, 1, 2, 2, 3'b000, 0, -1, -1);
        do_read(4'h3, 32'h700, 2, 3, 1, 3'b000, 0, -1, 1'b1);
        do_write(4'h4, 32'h800, 0, 1, 3, 3'b000, 0, -1, -1);
    endtask

    task automatic test_fixed_and_wrap_addr();
        do_write(4'h6, 32'h40, 2, 2, 0, 3'b100, 1, 1, -1);
        do_read(4'h7, 32'hFFFF_FFF8, 3, 2, 1, 3'b011, 0, -1, 1'b0);
        do_read(4'h8, 32'h1001, 2, 0, 1, 3'b000, 0, -1, 1'b0);
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        out_pready = 0;
        arvalid = 1; arid = 4'hC; araddr = 32'h1234_5678; arlen = 3; arsize = 2; arburst = 2'b01; arprot = 3'b111;
        #1;
        @(posedge clock); #1;
        arvalid = 0;
        while (out_penable !== 1'b1 && cyc < 10) begin @(posedge clock); #1; cyc++; end
        total++;
        if (out_penable !== 1'b1) begin bad++; $display("FAIL mid_reach_access penable=%b exp=1", out_penable); end
        #2;
        reset_n = 0;
        #1;
        total++;
        if ({awready, arready, wready, bvalid, rvalid, rlast, out_psel, out_penable, out_pwrite} !== 9'b0 ||
            {out_paddr, out_pwdata, out_pstrb, out_pprot, rdata, rresp, bresp, rid, bid} !== '0) begin
            bad++; $display("FAIL mid_reset_outputs ctl=%b paddr=%h pprot=%h exp all zero",
                            {awready, arready, wready, bvalid, rvalid, rlast, out_psel, out_penable, out_pwrite}, out_paddr, out_pprot);
        end
        @(negedge clock);
        reset_n = 1;
        @(posedge clock); #1;
        do_read(4'hD, 32'h0000_0020, 1, 2, 1, 3'b000, 0, -1, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            int len, size, burst, wait_n, err_beat;
            logic [31:0] addr;
            len = $urandom_range(0, 4);
            size = $urandom_range(0, 5) == 0 ? 3 : $urandom_range(0, 2);
            burst = $urandom_range(0, 4) == 0 ? $urandom_range(2, 3) : $urandom_range(0, 1);
            wait_n = $urandom_range(0, 3);
            err_beat = $urandom_range(0, len + 2) - 1;
            addr = $urandom;
            if ($urandom_range(0, 1) == 1)
                do_read(4'($urandom), addr, len, size, burst, 3'($urandom), wait_n, err_beat, 1'($urandom));
            else
                do_write(4'($urandom), addr, len, size, burst, 3'($urandom), wait_n, err_beat, -1);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_incr_write();
        test_wait_slverr();
        test_arbitration();
        test_error_bursts();
        test_fixed_and_wrap_addr();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
